time_entry_ctrl: RTL

- Keypad-side writer for the alarm-clock time registers.
- Collects decimal key presses into a 4-digit HH:MM entry buffer and validates the entry.
- On the time button, issues a one-cycle load_new_c strobe with new_current_time_* digits to the current-time counter. On the alarm button, issues load_new_a to the alarm register over the same digit bus.
- Provides display-select and error/timeout status.

---
 rtl/time_entry_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/time_entry_ctrl.sv
// Keypad-side writer for the alarm-clock time registers: collects HH:MM digits,
// validates them and strobes them into the current-time counter or alarm register.
module time_entry_ctrl #(
  parameter int unsigned TIMEOUT_SEC = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_second,
  input  logic       key_valid,
  input  logic [3:0] key,
  output logic [3:0] new_current_time_ms_hr,
  output logic [3:0] new_current_time_ls_hr,
  output logic [3:0] new_current_time_ms_min,
  output logic [3:0] new_current_time_ls_min,
  output logic       load_new_c,
  output logic       load_new_a,
  output logic       show_new_time,
  output logic       entry_error,
  output logic       entry_timeout,
  output logic [1:0] state_dbg_o
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ENTRY      = 2'd1,
    LOAD_TIME  = 2'd2,
    LOAD_ALARM = 2'd3
  } state_e;

  localparam logic [3:0] KEY_TIME  = 4'hA;
  localparam logic [3:0] KEY_ALARM = 4'hB;
  localparam logic [3:0] KEY_CLEAR = 4'hF;
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_SEC - 1);

  state_e     state_q, state_d;
  logic [3:0] ms_hr_q, ms_hr_d;
  logic [3:0] ls_hr_q, ls_hr_d;
  logic [3:0] ms_min_q, ms_min_d;
  logic [3:0] ls_min_q, ls_min_d;
  logic [2:0] count_q, count_d;
  logic [7:0] timer_q, timer_d;
  logic       error_q, error_d;
  logic       timeout_q, timeout_d;
  logic       is_digit;
  logic       entry_valid;

  assign is_digit = (key <= 4'd9);

  // Only a complete, legal 24-hour HH:MM entry may be loaded.
  assign entry_valid = (count_q == 3'd4) && (ms_hr_q <= 4'd2) && (ls_hr_q <= 4'd9) &&
                       ((ms_hr_q != 4'd2) || (ls_hr_q <= 4'd3)) &&
                       (ms_min_q <= 4'd5) && (ls_min_q <= 4'd9);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ms_hr_q   <= 4'd0;
      ls_hr_q   <= 4'd0;
      ms_min_q  <= 4'd0;
      ls_min_q  <= 4'd0;
      count_q   <= 3'd0;
      timer_q   <= 8'd0;
      error_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ms_hr_q   <= ms_hr_d;
      ls_hr_q   <= ls_hr_d;
      ms_min_q  <= ms_min_d;
      ls_min_q  <= ls_min_d;
      count_q   <= count_d;
      timer_q   <= timer_d;
      error_q   <= error_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ms_hr_d   = ms_hr_q;
    ls_hr_d   = ls_hr_q;
    ms_min_d  = ms_min_q;
    ls_min_d  = ls_min_q;
    count_d   = count_q;
    timer_d   = timer_q;
    error_d   = 1'b0;
    timeout_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        timer_d = 8'd0;
        if (key_valid && is_digit) begin
          ms_hr_d  = ls_hr_q;
          ls_hr_d  = ms_min_q;
          ms_min_d = ls_min_q;
          ls_min_d = key;
          count_d  = 3'd1;
          state_d  = ENTRY;
        end
      end

      ENTRY: begin
        if (key_valid) begin
          // Any key activity restarts the inactivity timer, even alongside a tick.
          timer_d = 8'd0;
          if (is_digit) begin
            ms_hr_d  = ls_hr_q;
            ls_hr_d  = ms_min_q;
            ms_min_d = ls_min_q;
            ls_min_d = key;
            count_d  = (count_q == 3'd4) ? 3'd4 : count_q + 3'd1;
          end else if (key == KEY_CLEAR) begin
            ms_hr_d  = 4'd0;
            ls_hr_d  = 4'd0;
            ms_min_d = 4'd0;
            ls_min_d = 4'd0;
            count_d  = 3'd0;
            state_d  = IDLE;
          end else if ((key == KEY_TIME) || (key == KEY_ALARM)) begin
            if (entry_valid) begin
              state_d = (key == KEY_TIME) ? LOAD_TIME : LOAD_ALARM;
            end else begin
              error_d  = 1'b1;
              ms_hr_d  = 4'd0;
              ls_hr_d  = 4'd0;
              ms_min_d = 4'd0;
              ls_min_d = 4'd0;
              count_d  = 3'd0;
              state_d  = IDLE;
            end
          end
        end else if (one_second) begin
          if (timer_q == TIMER_LAST) begin
            timeout_d = 1'b1;
            timer_d   = 8'd0;
            ms_hr_d   = 4'd0;
            ls_hr_d   = 4'd0;
            ms_min_d  = 4'd0;
            ls_min_d  = 4'd0;
            count_d   = 3'd0;
            state_d   = IDLE;
          end else begin
            timer_d = timer_q + 8'd1;
          end
        end
      end

      LOAD_TIME, LOAD_ALARM: begin
        // Buffer stays on the bus during the strobe cycle, then clears.
        ms_hr_d  = 4'd0;
        ls_hr_d  = 4'd0;
        ms_min_d = 4'd0;
        ls_min_d = 4'd0;
        count_d  = 3'd0;
        timer_d  = 8'd0;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign new_current_time_ms_hr  = ms_hr_q;
  assign new_current_time_ls_hr  = ls_hr_q;
  assign new_current_time_ms_min = ms_min_q;
  assign new_current_time_ls_min = ls_min_q;
  assign load_new_c              = (state_q == LOAD_TIME);
  assign load_new_a              = (state_q == LOAD_ALARM);
  assign show_new_time           = (state_q == ENTRY);
  assign entry_error             = error_q;
  assign entry_timeout           = timeout_q;
  assign state_dbg_o             = state_q;

endmodule
